// File: rtl/pipe_stage.sv
// Elastic pipeline stage register carrying a payload and a control bundle
// between core stages over valid/ready handshakes. Supports synchronous
// flush with bubble (NOP control) injection, an optional 2-entry skid
// buffer that registers in_ready, and a saturating stall-cycle counter.
module pipe_stage #(
  parameter int unsigned       DATA_W   = 32,
  parameter int unsigned       CTRL_W   = 16,
  parameter logic [CTRL_W-1:0] NOP_CTRL = '0,
  parameter int unsigned       SKID     = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] in_data,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic              flush,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [DATA_W-1:0] out_data,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [15:0]       stall_cnt
);

  logic in_xfer;
  logic out_xfer;

  assign in_xfer  = in_valid & in_ready;
  assign out_xfer = out_valid & out_ready;

  // Saturating count of cycles where a valid entry is held by downstream
  always_ff @(posedge clk) begin
    if (!rst) begin
      stall_cnt <= '0;
    end else if (out_valid && !out_ready && (stall_cnt != '1)) begin
      stall_cnt <= stall_cnt + 16'd1;
    end
  end

  generate
    if (SKID != 0) begin : g_skid
      typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        TWO   = 2'd2
      } state_t;

      state_t            state;
      state_t            state_nxt;
      logic              ready_q;
      logic [DATA_W-1:0] m_data;
      logic [CTRL_W-1:0] m_ctrl;
      logic [DATA_W-1:0] s_data;
      logic [CTRL_W-1:0] s_ctrl;

      // State register; in_ready is registered from the next state so no
      // combinational path exists from out_ready to in_ready
      always_ff @(posedge clk) begin
        if (!rst) begin
          state   <= EMPTY;
          ready_q <= 1'b1;
        end else begin
          state   <= state_nxt;
          ready_q <= (state_nxt != TWO);
        end
      end

      // Next-state: occupancy follows the handshakes, flush empties the stage
      always_comb begin
        state_nxt = state;
        unique case (state)
          EMPTY: if (in_xfer) state_nxt = ONE;
          ONE: begin
            if (in_xfer && !out_xfer)      state_nxt = TWO;
            else if (!in_xfer && out_xfer) state_nxt = EMPTY;
          end
          TWO:     if (out_xfer) state_nxt = ONE;
          default: state_nxt = EMPTY;
        endcase
        if (flush) state_nxt = EMPTY;
      end

      // Outputs decoded from the current state
      always_comb begin
        out_valid = (state != EMPTY);
        in_ready  = ready_q;
      end

      // Main/skid datapath; empty slots are cleared so bubbles carry NOP/0
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          m_data <= '0;
          m_ctrl <= NOP_CTRL;
          s_data <= '0;
          s_ctrl <= NOP_CTRL;
        end else begin
          unique case (state)
            EMPTY: begin
              if (in_xfer) begin
                m_data <= in_data;
                m_ctrl <= in_ctrl;
              end
            end
            ONE: begin
              if (in_xfer && out_xfer) begin
                m_data <= in_data;
                m_ctrl <= in_ctrl;
              end else if (in_xfer) begin
                s_data <= in_data;
                s_ctrl <= in_ctrl;
              end else if (out_xfer) begin
                m_data <= '0;
                m_ctrl <= NOP_CTRL;
              end
            end
            TWO: begin
              if (out_xfer) begin
                m_data <= s_data;
                m_ctrl <= s_ctrl;
                s_data <= '0;
                s_ctrl <= NOP_CTRL;
              end
            end
            default: ;
          endcase
        end
      end

      assign out_data = m_data;
      assign out_ctrl = m_ctrl;
    end else begin : g_single
      logic              valid_q;
      logic [DATA_W-1:0] m_data;
      logic [CTRL_W-1:0] m_ctrl;

      // Single holding register; empty slot is cleared to a bubble
      always_ff @(posedge clk) begin
        if (!rst || flush) begin
          valid_q <= 1'b0;
          m_data  <= '0;
          m_ctrl  <= NOP_CTRL;
        end else if (in_xfer) begin
          valid_q <= 1'b1;
          m_data  <= in_data;
          m_ctrl  <= in_ctrl;
        end else if (out_xfer) begin
          valid_q <= 1'b0;
          m_data  <= '0;
          m_ctrl  <= NOP_CTRL;
        end
      end

      assign out_valid = valid_q;
      assign in_ready  = out_ready | ~valid_q;
      assign out_data  = m_data;
      assign out_ctrl  = m_ctrl;
    end
  endgenerate

endmodule

// File: tb/tb_pipe_stage.sv
// Self-checking bench for pipe_stage: one SKID=0 and one SKID=1 instance
// compared every cycle against an occupancy/FIFO reference model.
module tb_pipe_stage;

  localparam logic [15:0] NOP0 = 16'h0000;
  localparam logic [15:0] NOP1 = 16'h00F0;

  logic        clk = 1'b0;
  logic        rst;
  logic        iv   [2];
  logic        ordy [2];
  logic        fl   [2];
  logic [31:0] id   [2];
  logic [15:0] ic   [2];
  logic        irdy [2];
  logic        ov   [2];
  logic [31:0] od   [2];
  logic [15:0] oc   [2];
  logic [15:0] sc   [2];

  always #5 clk = ~clk;

  pipe_stage #(.DATA_W(32), .CTRL_W(16), .NOP_CTRL(NOP0), .SKID(0)) u_single (
    .clk(clk), .rst(rst), .in_valid(iv[0]), .in_ready(irdy[0]),
    .in_data(id[0]), .in_ctrl(ic[0]), .flush(fl[0]), .out_valid(ov[0]),
    .out_ready(ordy[0]), .out_data(od[0]), .out_ctrl(oc[0]), .stall_cnt(sc[0])
  );

  pipe_stage #(.DATA_W(32), .CTRL_W(16), .NOP_CTRL(NOP1), .SKID(1)) u_skid (
    .clk(clk), .rst(rst), .in_valid(iv[1]), .in_ready(irdy[1]),
    .in_data(id[1]), .in_ctrl(ic[1]), .flush(fl[1]), .out_valid(ov[1]),
    .out_ready(ordy[1]), .out_data(od[1]), .out_ctrl(oc[1]), .stall_cnt(sc[1])
  );

  // Reference model: held entries in acceptance order, capacity 1 or 2
  logic [31:0] md [2][2];
  logic [15:0] mc [2][2];
  int          n   [2];
  int unsigned cnt [2];
  bit          acc [2];

  int n_chk  = 0;
  int n_fail = 0;

  task automatic check(input string tag, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, act, exp, $time);
    end
  endtask

  function automatic logic [15:0] nop(input int k);
    return (k == 1) ? NOP1 : NOP0;
  endfunction

  function automatic bit exp_rdy(input int k);
    if (k == 1) return (n[k] < 2);
    return (ordy[k] || (n[k] == 0));
  endfunction

  task automatic cycle();
    bit r, dep[2], stl[2], f[2];
    logic [31:0] d[2];
    logic [15:0] c[2];
    @(negedge clk);
    r = rst;
    for (int k = 0; k < 2; k++) begin
      check($sformatf("d%0d.out_valid", k), 64'(ov[k]), 64'(n[k] > 0));
      check($sformatf("d%0d.out_data", k), 64'(od[k]), 64'((n[k] > 0) ? md[k][0] : 32'h0));
      check($sformatf("d%0d.out_ctrl", k), 64'(oc[k]), 64'((n[k] > 0) ? mc[k][0] : nop(k)));
      check($sformatf("d%0d.in_ready", k), 64'(irdy[k]), 64'(exp_rdy(k)));
      check($sformatf("d%0d.stall_cnt", k), 64'(sc[k]), 64'(cnt[k]));
      acc[k] = r && iv[k] && exp_rdy(k);
      dep[k] = r && (n[k] > 0) && ordy[k];
      stl[k] = (n[k] > 0) && !ordy[k];
      f[k]   = fl[k];
      d[k]   = id[k];
      c[k]   = ic[k];
    end
    @(posedge clk);
    for (int k = 0; k < 2; k++) begin
      if (!r) begin
        n[k]   = 0;
        cnt[k] = 0;
      end else begin
        if (stl[k] && cnt[k] < 65535) cnt[k]++;
        if (dep[k]) begin
          md[k][0] = md[k][1];
          mc[k][0] = mc[k][1];
          n[k]--;
        end
        if (acc[k] && !f[k] && n[k] < 2) begin
          md[k][n[k]] = d[k];
          mc[k][n[k]] = c[k];
          n[k]++;
        end
        if (f[k]) n[k] = 0;
      end
    end
    #1;
  endtask

  task automatic set_in(input int k, input bit v, input logic [31:0] d, input logic [15:0] c);
    iv[k] = v;
    id[k] = v ? d : $urandom;
    ic[k] = v ? c : 16'($urandom);
  endtask

  task automatic offer(input int k, input logic [31:0] d, input logic [15:0] c);
    set_in(k, 1'b1, d, c);
    for (int i = 0; i < 20; i++) begin
      cycle();
      if (acc[k]) break;
    end
    set_in(k, 1'b0, 32'h0, 16'h0);
  endtask

  initial begin
    rst = 1'b0;
    for (int k = 0; k < 2; k++) begin
      set_in(k, 1'b0, 32'h0, 16'h0);
      ordy[k] = 1'b0;
      fl[k]   = 1'b0;
      n[k]    = 0;
      cnt[k]  = 0;
      acc[k]  = 1'b0;
    end
    @(posedge clk);
    #1;
    // Reset held for two checked cycles, with handshakes offered
    iv[1] = 1'b1;
    ordy[1] = 1'b1;
    repeat (2) cycle();
    set_in(1, 1'b0, 32'h0, 16'h0);
    rst = 1'b1;

    // Pass-through stream on the skid instance
    ordy[0] = 1'b1;
    offer(1, 32'h00400000, 16'h0011);
    offer(1, 32'h00400004, 16'h0012);
    offer(1, 32'h00400008, 16'h0013);
    repeat (3) cycle();

    // Backpressure fill: A held, B into skid, C refused until release
    ordy[1] = 1'b0;
    offer(1, 32'h11, 16'h0101);
    offer(1, 32'h22, 16'h0202);
    set_in(1, 1'b1, 32'h33, 16'h0303);
    repeat (4) cycle();
    ordy[1] = 1'b1;
    for (int i = 0; i < 10; i++) begin
      cycle();
      if (acc[1]) break;
    end
    set_in(1, 1'b0, 32'h0, 16'h0);
    repeat (4) cycle();

    // Flush while two entries held and D offered
    ordy[1] = 1'b0;
    offer(1, 32'h11, 16'h0101);
    offer(1, 32'h22, 16'h0202);
    set_in(1, 1'b1, 32'h44, 16'h0404);
    fl[1] = 1'b1;
    cycle();
    fl[1] = 1'b0;
    set_in(1, 1'b0, 32'h0, 16'h0);
    ordy[1] = 1'b1;
    repeat (3) cycle();

    // Flush in ONE discards the entry accepted the same cycle
    ordy[1] = 1'b0;
    offer(1, 32'h55, 16'h0505);
    set_in(1, 1'b1, 32'h66, 16'h0606);
    fl[1] = 1'b1;
    cycle();
    fl[1] = 1'b0;
    set_in(1, 1'b0, 32'h0, 16'h0);
    ordy[1] = 1'b1;
    repeat (2) cycle();

    // Single-register flush with simultaneous output and input transfer
    ordy[0] = 1'b0;
    offer(0, 32'h77, 16'h0707);
    set_in(0, 1'b1, 32'h88, 16'h0808);
    ordy[0] = 1'b1;
    fl[0] = 1'b1;
    cycle();
    fl[0] = 1'b0;
    set_in(0, 1'b0, 32'h0, 16'h0);
    repeat (2) cycle();

    // Single-register: in_ready follows out_ready in the same cycle
    set_in(0, 1'b1, 32'h99, 16'h0909);
    cycle();
    ordy[0] = 1'b1; set_in(0, 1'b1, 32'h9A, 16'h090A); cycle();
    ordy[0] = 1'b0; set_in(0, 1'b1, 32'h9B, 16'h090B); cycle();
    ordy[0] = 1'b1; set_in(0, 1'b1, 32'h9C, 16'h090C); cycle();
    set_in(0, 1'b0, 32'h0, 16'h0);
    repeat (2) cycle();

    // Random valid/ready/flush traffic on both instances
    for (int i = 0; i < 100; i++) begin
      for (int k = 0; k < 2; k++) begin
        set_in(k, bit'($urandom_range(0, 2) != 0), $urandom, 16'($urandom));
        ordy[k] = ($urandom_range(0, 3) != 0);
        fl[k]   = ($urandom_range(0, 24) == 0);
      end
      cycle();
    end
    for (int k = 0; k < 2; k++) begin
      set_in(k, 1'b0, 32'h0, 16'h0);
      fl[k]   = 1'b0;
      ordy[k] = 1'b1;
    end
    repeat (3) cycle();

    // Reset takes priority over flush while in ONE
    ordy[1] = 1'b0;
    offer(1, 32'hAA, 16'h0A0A);
    cycle();
    rst   = 1'b0;
    fl[1] = 1'b1;
    cycle();
    rst   = 1'b1;
    fl[1] = 1'b0;
    repeat (2) cycle();

    // Stall counter saturation, then clear by reset
    ordy[0] = 1'b0;
    ordy[1] = 1'b0;
    offer(0, 32'hBB, 16'h0B0B);
    offer(1, 32'hCC, 16'h0C0C);
    repeat (65545) cycle();
    rst = 1'b0;
    cycle();
    rst = 1'b1;
    repeat (2) cycle();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
